// File: rtl/clock_gen_if.sv
// Control/status bundle between the clock generator and whatever drives it.
// Latency: none, this file only groups signals.
// Backpressure: none. The generator always accepts halt and div_load.
interface clock_gen_if #(
   parameter int DIV_W = 8
);
   logic             halt;
   logic [DIV_W-1:0] div_ratio;
   logic             div_load;
   logic             clk_out;
   logic             tick;
   logic             running;
   logic [63:0]      cycle_count;

   // The controller drives the requests and observes the generated clock.
   modport master (
      output halt, div_ratio, div_load,
      input  clk_out, tick, running, cycle_count
   );

   // The generator receives the requests and drives the clock/status.
   modport slave (
      input  halt, div_ratio, div_load,
      output clk_out, tick, running, cycle_count
   );
endinterface

// File: rtl/clock_gen.sv
// Programmable glitch-free divided clock with halt and a tick strobe.
// Outputs are registered. clk_out and tick rise on the first edge after a start.
// No backpressure. Ratio loads and halt requests act at period boundaries.
// Optional feature macro: CLOCK_GEN_CYCLE_COUNT_EN adds a 64-bit rising-edge counter.
module clock_gen #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic     clk,
   input  logic     reset,
   clock_gen_if.slave bus
);

   localparam logic [DIV_W-1:0] L_ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] L_TWO     = DIV_W'(2);
   localparam logic [DIV_W-1:0] L_DEF_DIV = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           r_state,   w_state_nxt;
   logic [DIV_W-1:0] r_phase,   w_phase_nxt;
   logic [DIV_W-1:0] r_active,  w_active_nxt;
   logic [DIV_W-1:0] r_pending, w_pending_nxt;
   logic             r_clk_out, w_clk_out_nxt;
   logic             r_tick,    w_tick_nxt;

   logic [DIV_W-1:0] w_hi;
   logic [DIV_W-1:0] w_phase_inc;
   logic [DIV_W-1:0] w_ratio_in;
   logic             w_last;
   logic             w_start;

   // High phase is ceil(N/2). Written as floor + lsb so it never overflows DIV_W.
   assign w_hi        = {1'b0, r_active[DIV_W-1:1]} + {{(DIV_W-1){1'b0}}, r_active[0]};
   assign w_phase_inc = r_phase + L_ONE;
   assign w_last      = (r_phase == (r_active - L_ONE));
   assign w_ratio_in  = (bus.div_ratio < L_TWO) ? L_TWO : bus.div_ratio;

   // A period starts on leaving the stopped state, or at the end of a period.
   // In both cases halt must be low. halt is only sampled at these points.
   assign w_start = !bus.halt && ((r_state == ST_STOP) || w_last);

   // Next-state logic: sequence the phase counter and decide the next clk_out level.
   always_comb begin
      w_state_nxt   = r_state;
      w_phase_nxt   = r_phase;
      w_active_nxt  = r_active;
      w_clk_out_nxt = r_clk_out;
      w_tick_nxt    = 1'b0;
      w_pending_nxt = bus.div_load ? w_ratio_in : r_pending;

      if (w_start) begin
         // A new period adopts the ratio that was pending before this edge.
         // A load on this same edge therefore applies to the next period.
         w_state_nxt   = ST_RUN;
         w_phase_nxt   = '0;
         w_active_nxt  = r_pending;
         w_clk_out_nxt = 1'b1;
         w_tick_nxt    = 1'b1;
      end else if (r_state == ST_RUN) begin
         if (w_last) begin
            // The boundary was reached with halt high. Park low.
            w_state_nxt   = ST_STOP;
            w_phase_nxt   = '0;
            w_clk_out_nxt = 1'b0;
         end else begin
            w_phase_nxt   = w_phase_inc;
            w_clk_out_nxt = (w_phase_inc < w_hi);
         end
      end
   end

   // State and output registers. Reset clears everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_STOP;
         r_phase   <= '0;
         r_active  <= L_DEF_DIV;
         r_pending <= L_DEF_DIV;
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_active  <= w_active_nxt;
         r_pending <= w_pending_nxt;
         r_clk_out <= w_clk_out_nxt;
         r_tick    <= w_tick_nxt;
      end
   end

   assign bus.clk_out = r_clk_out;
   assign bus.tick    = r_tick;
   assign bus.running = (r_state == ST_RUN);

`ifdef CLOCK_GEN_CYCLE_COUNT_EN
   logic [63:0] r_cycle_count;

   // Count clk_out rising edges. The counter wraps naturally at 2^64.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle_count <= '0;
      end else if (w_start) begin
         r_cycle_count <= r_cycle_count + 64'd1;
      end
   end

   assign bus.cycle_count = r_cycle_count;
`else
   assign bus.cycle_count = 64'h0;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen with hand-computed per-cycle expectations.
// Outputs are sampled 1 time unit after each rising clk edge.
// No backpressure. Inputs change right after sampling.
module tb_clock_gen;

   logic clk;
   logic reset;

   clock_gen_if #(.DIV_W(8)) u_if ();

   clock_gen #(
      .DIV_W       (8),
      .DEFAULT_DIV (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.slave)
   );

   int          n_chk;
   int          n_pass;
   int          cyc;
   logic [63:0] exp_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clk cycle and check every output against the expectation.
   task automatic step_chk(input string tag, input logic e_clk, input logic e_tick, input logic e_run);
      @(posedge clk);
      #1;
      cyc++;
      if (e_tick) exp_cnt = exp_cnt + 64'd1;
      check($sformatf("%s c%0d clk_out", tag, cyc), {63'b0, u_if.clk_out}, {63'b0, e_clk});
      check($sformatf("%s c%0d tick", tag, cyc),    {63'b0, u_if.tick},    {63'b0, e_tick});
      check($sformatf("%s c%0d running", tag, cyc), {63'b0, u_if.running}, {63'b0, e_run});
`ifdef CLOCK_GEN_CYCLE_COUNT_EN
      check($sformatf("%s c%0d count", tag, cyc), u_if.cycle_count, exp_cnt);
`else
      check($sformatf("%s c%0d count", tag, cyc), u_if.cycle_count, 64'h0);
`endif
   endtask

   task automatic chk_reset_state(input string tag);
      check({tag, " clk_out"}, {63'b0, u_if.clk_out}, 64'h0);
      check({tag, " tick"},    {63'b0, u_if.tick},    64'h0);
      check({tag, " running"}, {63'b0, u_if.running}, 64'h0);
      check({tag, " count"},   u_if.cycle_count,      64'h0);
   endtask

   initial begin
      n_chk        = 0;
      n_pass       = 0;
      cyc          = 0;
      exp_cnt      = '0;
      reset        = 1'b1;
      u_if.halt      = 1'b0;
      u_if.div_ratio = 8'd0;
      u_if.div_load  = 1'b0;

      // Assert reset before the first edge and check the cleared state.
      #2 reset = 1'b0;
      #1 chk_reset_state("rst");
      @(posedge clk);
      #1 chk_reset_state("rst_edge");
      reset = 1'b0;
      reset = 1'b1;

      // Default N=2: clk_out 1,0,1,0... with tick on the odd cycles.
      for (int i = 1; i <= 6; i++) begin
         step_chk("n2", (i % 2) == 1, (i % 2) == 1, 1'b1);
      end
      step_chk("n2", 1, 1, 1);            // c7: period start
      u_if.div_ratio = 8'd5;
      u_if.div_load  = 1'b1;
      step_chk("ld5", 0, 0, 1);           // c8: current N=2 period unchanged
      u_if.div_load  = 1'b0;

      // N=5: 3 high / 2 low.
      step_chk("n5", 1, 1, 1);            // c9
      step_chk("n5", 1, 0, 1);
      step_chk("n5", 1, 0, 1);
      step_chk("n5", 0, 0, 1);
      step_chk("n5", 0, 0, 1);            // c13: last cycle of the period
      u_if.div_ratio = 8'd0;
      u_if.div_load  = 1'b1;              // captured on the c14 start edge
      step_chk("n5", 1, 1, 1);            // c14: still N=5
      u_if.div_load  = 1'b0;
      step_chk("n5", 1, 0, 1);
      step_chk("n5", 1, 0, 1);
      step_chk("n5", 0, 0, 1);
      step_chk("n5", 0, 0, 1);            // c18

      // Ratio 0 is clamped to 2.
      step_chk("r0", 1, 1, 1);            // c19
      step_chk("r0", 0, 0, 1);
      step_chk("r0", 1, 1, 1);            // c21
      u_if.div_ratio = 8'd1;
      u_if.div_load  = 1'b1;
      step_chk("r1", 0, 0, 1);            // c22
      u_if.div_load  = 1'b0;
      step_chk("r1", 1, 1, 1);            // c23: ratio 1 clamped to 2
      u_if.div_ratio = 8'd4;
      u_if.div_load  = 1'b1;
      step_chk("r1", 0, 0, 1);            // c24
      u_if.div_load  = 1'b0;

      // N=4, halt raised during the high phase.
      step_chk("n4", 1, 1, 1);            // c25
      u_if.halt = 1'b1;
      step_chk("hlt", 1, 0, 1);
      step_chk("hlt", 0, 0, 1);
      step_chk("hlt", 0, 0, 1);           // c28: low phase completes
      step_chk("hlt", 0, 0, 0);           // c29: rise suppressed
      step_chk("hlt", 0, 0, 0);           // c30
      u_if.halt = 1'b0;
      step_chk("rel", 1, 1, 1);           // c31: restart
      step_chk("rel", 1, 0, 1);
      step_chk("rel", 0, 0, 1);
      step_chk("rel", 0, 0, 1);
      step_chk("rel", 1, 1, 1);           // c35

      // A halt pulse that ends before the boundary has no effect.
      u_if.halt = 1'b1;
      step_chk("pulse", 1, 0, 1);         // c36
      u_if.halt = 1'b0;
      step_chk("pulse", 0, 0, 1);
      step_chk("pulse", 0, 0, 1);
      step_chk("pulse", 1, 1, 1);         // c39
      step_chk("pulse", 1, 0, 1);
      step_chk("pulse", 0, 0, 1);         // c41: mid low phase

      // Asynchronous reset in the low phase clears outputs before the next edge.
      reset = 1'b0;
      #1 chk_reset_state("arst");
      @(posedge clk);
      #1 chk_reset_state("arst_edge");
      reset   = 1'b1;
      exp_cnt = '0;

      // After reset the ratio is back to the default N=2.
      step_chk("post", 1, 1, 1);
      step_chk("post", 0, 0, 1);
      step_chk("post", 1, 1, 1);
      step_chk("post", 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
